// File: rtl/fixed_to_float_pkg.sv
// Shared helpers for the fixed-point to IEEE-754 converter: exponent bias and
// packed float width derived from the exponent/mantissa field sizes.
package fixed_to_float_pkg;

  function automatic int float_bias(input int exp_width);
    return (1 << (exp_width - 1)) - 1;
  endfunction

  function automatic int float_width(input int exp_width, input int man_width);
    return 1 + exp_width + man_width;
  endfunction

endpackage

// File: rtl/lzc_count.sv
// Combinational leading-zero counter; count equals WIDTH when the input is zero.
module lzc_count
  import fixed_to_float_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]           value,
  output logic [$clog2(WIDTH+1)-1:0] count,
  output logic                       all_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  // Ascending scan so the highest set bit is the last one to win.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

  assign all_zero = ~|value;

endmodule

// File: rtl/fixed_to_float_pipe.sv
// Four-stage fixed-point (Qm.f) to packed IEEE-754 converter with per-stage
// bubble collapse. Define FIXED_TO_FLOAT_STATUS_EN to add the status output.
module fixed_to_float_pipe
  import fixed_to_float_pkg::*;
#(
  parameter int IN_WIDTH   = 32,
  parameter int FRAC_BITS  = 16,
  parameter int IN_SIGNED  = 1,
  parameter int EXP_WIDTH  = 8,
  parameter int MAN_WIDTH  = 23,
  parameter int USER_WIDTH = 1
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic [IN_WIDTH-1:0]                  s_axis_a_tdata,
  input  logic [USER_WIDTH-1:0]                s_axis_a_tuser,
  input  logic                                 s_axis_a_tvalid,
  output logic                                 s_axis_a_tready,
  output logic [float_width(EXP_WIDTH, MAN_WIDTH)-1:0] m_axis_result_tdata,
  output logic [USER_WIDTH-1:0]                m_axis_result_tuser,
  output logic                                 m_axis_result_tvalid,
  input  logic                                 m_axis_result_tready
`ifdef FIXED_TO_FLOAT_STATUS_EN
  ,
  output logic [1:0]                           m_axis_result_tstatus
`endif
);

  localparam int  BIAS     = float_bias(EXP_WIDTH);
  localparam int  OUT_W    = float_width(EXP_WIDTH, MAN_WIDTH);
  localparam int  LZC_W    = $clog2(IN_WIDTH + 1);
  localparam int  FRAC_W   = IN_WIDTH - 1;
  localparam bit  ROUND_EN = (IN_WIDTH - 1) > MAN_WIDTH;

  // These bounds keep every result normal and finite, so no overflow or
  // subnormal handling is needed downstream.
  if (FRAC_BITS > BIAS - 1) begin : g_frac_too_big
    $error("FRAC_BITS must not exceed bias-1");
  end
  if (IN_WIDTH - FRAC_BITS > BIAS) begin : g_int_too_big
    $error("IN_WIDTH-FRAC_BITS must not exceed bias");
  end
  if (FRAC_BITS >= IN_WIDTH) begin : g_frac_ge_width
    $error("FRAC_BITS must be smaller than IN_WIDTH");
  end

  typedef struct packed {
    logic                  sign;
    logic [IN_WIDTH-1:0]   mag;
    logic [USER_WIDTH-1:0] user;
  } s1_t;

  typedef struct packed {
    logic                  sign;
    logic [IN_WIDTH-1:0]   mag;
    logic [LZC_W-1:0]      lzc;
    logic                  zero;
    logic [USER_WIDTH-1:0] user;
  } s2_t;

  typedef struct packed {
    logic                  sign;
    logic [FRAC_W-1:0]     frac;
    logic signed [EXP_WIDTH:0] exp;
    logic                  zero;
    logic [USER_WIDTH-1:0] user;
  } s3_t;

  // Handshake: a beat moves when valid && ready; a stage advances when it is
  // empty or the stage after it advances, so bubbles collapse anywhere.
  logic v1, v2, v3;
  logic adv1, adv2, adv3, adv4;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;

  assign adv4 = !m_axis_result_tvalid || m_axis_result_tready;
  assign adv3 = !v3 || adv4;
  assign adv2 = !v2 || adv3;
  assign adv1 = !v1 || adv2;
  assign s_axis_a_tready = adv1 && !aresetn;

  always_comb begin
    s1_d.sign = (IN_SIGNED != 0) && s_axis_a_tdata[IN_WIDTH-1];
    s1_d.mag  = s1_d.sign ? -s_axis_a_tdata : s_axis_a_tdata;
    s1_d.user = s_axis_a_tuser;
  end

  logic [LZC_W-1:0] lzc_cnt;
  logic             lzc_zero;

  lzc_count #(.WIDTH(IN_WIDTH)) u_lzc (
    .value    (s1_q.mag),
    .count    (lzc_cnt),
    .all_zero (lzc_zero)
  );

  always_comb begin
    s2_d.sign = s1_q.sign;
    s2_d.mag  = s1_q.mag;
    s2_d.lzc  = lzc_cnt;
    s2_d.zero = lzc_zero;
    s2_d.user = s1_q.user;
  end

  // The leading one is implicit in the float format and is dropped here.
  logic unused_lead;
  always_comb begin
    {unused_lead, s3_d.frac} = s2_q.mag << s2_q.lzc;
    s3_d.sign = s2_q.sign;
    s3_d.exp  = (EXP_WIDTH+1)'(IN_WIDTH - 1 - FRAC_BITS - int'(s2_q.lzc));
    s3_d.zero = s2_q.zero;
    s3_d.user = s2_q.user;
  end

  logic [FRAC_W+MAN_WIDTH-1:0] ext;
  logic [MAN_WIDTH-1:0]        man_t;
  logic [FRAC_W-1:0]           dropped;
  logic                        guard, sticky, inc;
  logic [MAN_WIDTH:0]          man_sum;
  logic [OUT_W-1:0]            res;

  // Zero-padding below the fraction makes the exact case fall out naturally:
  // when the fraction fits, every dropped bit is zero.
  always_comb begin
    ext     = {s3_q.frac, {MAN_WIDTH{1'b0}}};
    man_t   = ext[FRAC_W+MAN_WIDTH-1 -: MAN_WIDTH];
    dropped = ext[FRAC_W-1:0];
    guard   = dropped[FRAC_W-1];
    sticky  = |(dropped << 1);
    inc     = ROUND_EN && guard && (sticky || man_t[0]);
    man_sum = {1'b0, man_t} + (MAN_WIDTH+1)'(inc);
    if (s3_q.zero) begin
      res = '0;
    end else begin
      res = {s3_q.sign,
             EXP_WIDTH'(int'(s3_q.exp) + int'(man_sum[MAN_WIDTH]) + BIAS),
             man_sum[MAN_WIDTH-1:0]};
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn) begin
      v1                   <= 1'b0;
      v2                   <= 1'b0;
      v3                   <= 1'b0;
      m_axis_result_tvalid <= 1'b0;
      m_axis_result_tdata  <= '0;
      m_axis_result_tuser  <= '0;
`ifdef FIXED_TO_FLOAT_STATUS_EN
      m_axis_result_tstatus <= 2'b00;
`endif
    end else begin
      if (adv1) v1 <= s_axis_a_tvalid;
      if (adv2) v2 <= v1;
      if (adv3) v3 <= v2;
      if (adv4) begin
        m_axis_result_tvalid <= v3;
        if (v3) begin
          m_axis_result_tdata <= res;
          m_axis_result_tuser <= s3_q.user;
`ifdef FIXED_TO_FLOAT_STATUS_EN
          m_axis_result_tstatus <= {s3_q.zero, guard | sticky};
`endif
        end
      end
    end
  end

  // Payload registers need no reset: their valids gate every use.
  always_ff @(posedge aclk) begin
    if (adv1 && s_axis_a_tvalid) s1_q <= s1_d;
    if (adv2 && v1)              s2_q <= s2_d;
    if (adv3 && v2)              s3_q <= s3_d;
  end

endmodule

// File: doc/fixed_to_float_pipe.md
Name: fixed_to_float_pipe

Overview:
- Synthesizable, parametrised fixed-point to IEEE-754 floating-point converter for the compute datapath.
- Accepts a signed or unsigned Qm.f word on an AXI-Stream-style slave port.
- Emits a packed float (default binary32) on a master port through a 4-stage pipeline with per-stage bubble collapse.
- Passes a user sideband through alongside the data.

Parameters:
IN_WIDTH, 32, total input bits
FRAC_BITS, 16, fractional bits of input
IN_SIGNED, 1, 1 = two's-complement input, 0 = unsigned
EXP_WIDTH, 8, output exponent bits
MAN_WIDTH, 23, output stored-mantissa bits
USER_WIDTH, 1, sideband bits carried with each sample

Ports:
aclk  in  1  clock
aresetn  in  1  reset; synchronous, active-high despite the suffix
s_axis_a_tdata  in  IN_WIDTH  fixed-point input
s_axis_a_tuser  in  USER_WIDTH  sideband, carried with the sample
s_axis_a_tvalid  in  1  input valid
s_axis_a_tready  out  1  input ready
m_axis_result_tdata  out  1+EXP_WIDTH+MAN_WIDTH  {sign, exponent, mantissa}
m_axis_result_tuser  out  USER_WIDTH  sideband of the output sample
m_axis_result_tvalid  out  1  result valid
m_axis_result_tready  in  1  downstream ready

Behaviour:
- Reset, checked before the advance logic in the same clocked block:
  - all stage valids are cleared;
  - m_axis_result_tvalid=0, tdata=0, tuser=0 the cycle after aresetn is sampled high;
  - s_axis_a_tready=0 while aresetn=1.
- Reset mid-operation discards all in-flight samples; no partial outputs.
- Handshake: transfer occurs when valid && ready. An output, once valid, holds tdata/tuser stable until accepted.
- Stage k advances when its valid is 0 or stage k+1 advances. Stage 4 advances when !m_tvalid || m_tready. s_axis_a_tready = stage-1 advance.
- Throughput is 1 sample/clock when unstalled. Latency is exactly 4 clocks from input acceptance to m_tvalid.
- Stage 1: sign = IN_SIGNED & msb. Magnitude = abs value as unsigned IN_WIDTH bits, so the most negative input gives 2^(IN_WIDTH-1) with no overflow.
- Stage 2: leading-zero count of the magnitude; zero flag when the magnitude is 0.
- Stage 3: left-shift the magnitude so its msb sits at bit IN_WIDTH-1. Unbiased exponent = IN_WIDTH-1-FRAC_BITS-lzc.
- Stage 4, round-to-nearest-even:
  - guard = first dropped bit; sticky = OR of the remaining dropped bits.
  - Increment when guard && (sticky || mantissa lsb).
  - Mantissa carry-out sets the mantissa to 0 and adds 1 to the exponent.
  - If IN_WIDTH-1 <= MAN_WIDTH, the conversion is exact (no rounding).
  - Pack: biased exponent = exponent + (2^(EXP_WIDTH-1)-1).
- Zero input gives +0 (all zeros). Negative zero never occurs.
- Elaboration-time assertions, which exclude overflow and subnormals by construction:
  - FRAC_BITS <= bias-1;
  - IN_WIDTH-FRAC_BITS <= bias;
  - FRAC_BITS < IN_WIDTH.

Optional Feature:
- Macro: FIXED_TO_FLOAT_STATUS_EN.
- Defined: adds output port m_axis_result_tstatus[1:0], registered and aligned with tdata.
  - bit0 = inexact (guard|sticky nonzero);
  - bit1 = zero;
  - resets to 0.
- Undefined: the port and the status pipeline registers are absent; datapath behaviour is identical.

Decomposition:
- Package fixed_to_float_pkg:
  - function float_bias(EXP_WIDTH);
  - localparam helper for output width;
  - stage-payload struct typedefs parameterised via a macro or per-instance localparams.
- One sub-module, lzc_count: combinational leading-zero counter.
  - Parameters: WIDTH.
  - Outputs: count of $clog2(WIDTH+1) bits, all_zero flag.
  - Instantiated in stage 2.

Test Plan:
All cases use default parameters (Q16.16 signed -> binary32) unless stated.
- 0x00010000 (1.0) -> 0x3F800000 exactly 4 clocks after acceptance; 0xFFFF0000 -> 0xBF800000.
- 0x80000000 (-32768.0) -> 0xC7000000; 0x00000001 (2^-16) -> 0x37800000; 0x00000000 -> 0x00000000, status zero=1.
- Rounding:
  - 0x01000001 (tie) -> 0x43800000 (round to even), inexact=1;
  - 0x01000003 -> 0x43800002;
  - 0x7FFFFFFF -> carry into exponent -> 0x47000000.
- Backpressure:
  - Issue 10 back-to-back samples with m_tready toggled on a random pattern, held low 5 cycles mid-burst.
  - Required: all 10 outputs in order, tdata/tuser stable while stalled.
  - Required: s_tready drops only once the pipeline is full.
  - Required: 1 sample/clock when tready is held high.
- Reset mid-operation: assert aresetn with 3 samples in flight -> m_tvalid=0 the next cycle; no stale outputs after release; first new sample appears 4 clocks after acceptance.
- IN_SIGNED=0, IN_WIDTH=16, FRAC_BITS=0: 0xFFFF -> 0x477FFF00 exact, inexact=0; sideband value 1 appears on tuser with its sample.
